// File: rtl/bus_result_monitor.sv
`default_nettype none
// ============================================================================
// Module      : bus_result_monitor
// Description : Passive observer on the CPU memory bus. Waits for the first
//               opcode fetch, then watches for the signature write to
//               RESULT_ADDR and compares the written byte against EXPECT.
//               Reports PASS, FAIL or TIMEOUT on sticky flags and never
//               drives the bus.
//
// Ports       : ph2          - sole clock, rising-edge active
//               reset        - asynchronous active-high reset
//               addr         - CPU address bus
//               data         - CPU write data (valid with memwrite)
//               memwrite     - write strobe for the current cycle
//               fetch        - opcode-fetch strobe for the current cycle
//               done         - test finished (pass | fail | timeout)
//               pass         - signature matched
//               fail         - signature mismatched or trap detected
//               timeout      - TIMEOUT_CYC cycles in RUN without signature
//               trap         - fail was caused by a fetch trap
//               result       - byte captured from the signature write
//               write_count  - writes seen in RUN, saturating at 255
//
// Options     : `define TRAP_DETECT_EN to enable JMP-to-self trap detection
//               (TRAP_COUNT consecutive fetches from one address -> FAIL).
//
// Revision    : 1.0 - initial release
// ============================================================================
module bus_result_monitor #(
    parameter int                 ADDR_W      = 16,
    parameter int                 DATA_W      = 8,
    parameter logic [ADDR_W-1:0]  RESULT_ADDR = 16'h0042,
    parameter logic [DATA_W-1:0]  EXPECT      = 8'hA5,
    parameter int                 TIMEOUT_CYC = 150,
    parameter int                 TRAP_COUNT  = 4
) (
    input  logic              ph2,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic              memwrite,
    input  logic              fetch,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic              trap,
    output logic [DATA_W-1:0] result,
    output logic [7:0]        write_count
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_cnt_w = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYC - 1);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_run  = 3'd1;
    localparam logic [2:0] c_st_pass = 3'd2;
    localparam logic [2:0] c_st_fail = 3'd3;
    localparam logic [2:0] c_st_tmo  = 3'd4;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [c_cnt_w-1:0] r_cycle_cnt;
    logic [DATA_W-1:0]  r_result;
    logic [7:0]         r_write_count;
    logic               r_trap;

    logic w_in_run;
    logic w_sig_write;
    logic w_sig_match;
    logic w_expired;
    logic w_trap_hit;

    assign w_in_run    = (r_state == c_st_run);
    assign w_sig_write = memwrite && (addr == RESULT_ADDR);
    // An unknown data value cannot compare equal, so an X signature falls
    // through to the FAIL branch of the next-state logic.
    assign w_sig_match = (data == EXPECT);
    assign w_expired   = (r_cycle_cnt == c_cnt_last);

`ifdef TRAP_DETECT_EN
    // ------------------------------------------------------------------------
    // Trap detection: count consecutive fetches from the same address. The
    // fetch that moves IDLE -> RUN seeds the run length with 1, so a CPU that
    // starts life already spinning is caught after TRAP_COUNT fetches total.
    // ------------------------------------------------------------------------
    localparam int c_trap_w = $clog2(TRAP_COUNT) + 1;
    localparam logic [c_trap_w-1:0] c_trap_last = c_trap_w'(TRAP_COUNT - 1);

    logic [ADDR_W-1:0]   r_last_fetch;
    logic [c_trap_w-1:0] r_run_len;
    logic                w_same_fetch;

    assign w_same_fetch = fetch && (addr == r_last_fetch);
    // Fires on the fetch that would bring the run length up to TRAP_COUNT.
    assign w_trap_hit   = w_in_run && w_same_fetch && (r_run_len == c_trap_last);

    always_ff @(posedge ph2 or posedge reset) begin
        if (reset) begin
            r_last_fetch <= '0;
            r_run_len    <= '0;
        end else if (fetch && ((r_state == c_st_idle) || w_in_run)) begin
            r_last_fetch <= addr;
            if (w_in_run && w_same_fetch) begin
                r_run_len <= r_run_len + 1'b1;
            end else begin
                r_run_len <= c_trap_w'(1);
            end
        end
    end
`else
    // Trap detection absent: the flag can never be raised. TRAP_COUNT is
    // folded into a sink so the parameter stays referenced.
    logic w_unused_trap_cfg;
    assign w_unused_trap_cfg = ^TRAP_COUNT;
    assign w_trap_hit        = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Next-state logic. Within RUN the signature write has priority over a
    // trap, which in turn has priority over timeout expiry.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (fetch) begin
                    w_next_state = c_st_run;
                end
            end
            c_st_run: begin
                if (w_sig_write) begin
                    if (w_sig_match) begin
                        w_next_state = c_st_pass;
                    end else begin
                        w_next_state = c_st_fail;
                    end
                end else if (w_trap_hit) begin
                    w_next_state = c_st_fail;
                end else if (w_expired) begin
                    w_next_state = c_st_tmo;
                end
            end
            c_st_pass,
            c_st_fail,
            c_st_tmo: begin
                w_next_state = r_state;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequential state. Counters and captured values only move in RUN, so
    // they are frozen both before the first fetch and after a verdict.
    // ------------------------------------------------------------------------
    always_ff @(posedge ph2 or posedge reset) begin
        if (reset) begin
            r_state       <= c_st_idle;
            r_cycle_cnt   <= '0;
            r_result      <= '0;
            r_write_count <= '0;
            r_trap        <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (w_in_run) begin
                // Cannot wrap: RUN is left at c_cnt_last at the latest.
                r_cycle_cnt <= r_cycle_cnt + 1'b1;

                if (w_sig_write) begin
                    r_result <= data;
                end

                if (memwrite && (r_write_count != 8'hFF)) begin
                    r_write_count <= r_write_count + 8'd1;
                end

                if (!w_sig_write && w_trap_hit) begin
                    r_trap <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: verdict flags decode directly from the state register, which
    // keeps them mutually exclusive and lets reset clear them immediately.
    // ------------------------------------------------------------------------
    assign pass        = (r_state == c_st_pass);
    assign fail        = (r_state == c_st_fail);
    assign timeout     = (r_state == c_st_tmo);
    assign done        = pass || fail || timeout;
    assign trap        = r_trap;
    assign result      = r_result;
    assign write_count = r_write_count;

endmodule
`default_nettype wire
